// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg
//   Shared encodings for the multicycle RV32I control path: FSM state
//   enumeration, opcode constants, datapath select encodings and the
//   opcode-level decode helpers used by the controller.
//   No ports (package).
package core_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10
    } state_t;

    // Opcodes handled by this core
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Internal ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // ImmSrc
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // ResultSrc
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // ALUSrcA / ALUSrcB
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Immediate format for the extender; unknown opcodes fall back to I
    // so the extender input is never undefined.
    function automatic logic [2:0] imm_src_dec(input logic [6:0] op);
        logic [2:0] imm;
        case (op)
            OP_STORE:  imm = IMM_S;
            OP_BRANCH: imm = IMM_B;
            OP_JAL:    imm = IMM_J;
            OP_AUIPC:  imm = IMM_U;
            default:   imm = IMM_I;
        endcase
        return imm;
    endfunction

    // True for every opcode the DECODE state can dispatch
    function automatic logic op_supported(input logic [6:0] op);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_IALU,
            OP_BRANCH, OP_JAL, OP_AUIPC: ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if
//   Bundle between the control FSM and the datapath/memory.
//   master : controller side (instruction fields, zero, mem_ready in;
//            handshake, selects and enables out)
//   slave  : datapath/memory side (mirror image)
interface multicycle_ctrl_if;

    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic       illegal_op;
    logic       bus_err;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite,
               illegal_op, bus_err
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegWrite,
               illegal_op, bus_err
    );

endinterface

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec
//   Combinational ALU operation decoder.
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct3/funct7b5
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   op5         in  1  instr[5], distinguishes R-type from I-ALU
//   alu_control out 3  ALU operation select
module alu_ctrl_dec
    import core_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    // ALU operation select from ALUOp and the function fields
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // instr[30] only means sub for R-type; addi ignores it
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of the multicycle RV32I core. Sequences the shared
//   memory, IR, PC and ALU through fetch/decode/execute/memory/writeback
//   and drives every datapath select and enable.
//   clk      in  core clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   bus      multicycle_ctrl_if.master: instruction fields, zero and
//            mem_ready in; mem_req, selects, enables, illegal_op, bus_err out
//   TIMEOUT_CYCLES: wait cycles allowed per memory access (0 = no limit)
//   CNT_W         : wait counter width, TIMEOUT_CYCLES < 2**CNT_W
module multicycle_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    multicycle_ctrl_if.master  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE       = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit               TIMEOUT_EN    = (TIMEOUT_CYCLES > 0);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             timeout_s;
    logic             branch_taken_s;

    logic             mem_req_s;
    logic             pc_write_s;
    logic             adr_src_s;
    logic             mem_write_s;
    logic             ir_write_s;
    logic             reg_write_s;
    logic             illegal_op_s;
    logic [1:0]       result_src_s;
    logic [1:0]       alu_src_a_s;
    logic [1:0]       alu_src_b_s;
    logic [1:0]       alu_op_s;
    logic [2:0]       alu_control_s;

    // A late mem_ready in the limit cycle still completes the access
    assign timeout_s = TIMEOUT_EN && mem_req_s && !bus.mem_ready
                       && (wait_cnt_r == TIMEOUT_LIMIT);

    // beq taken on zero, bne on !zero; other branch funct3 never taken
    assign branch_taken_s = ((bus.funct3 == 3'b000) &&  bus.zero) ||
                            ((bus.funct3 == 3'b001) && !bus.zero);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory wait counter; every exit from a request state goes through
    // mem_ready or a timeout, so those two events are enough to clear it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (!mem_req_s || bus.mem_ready || timeout_s) begin
            wait_cnt_r <= CNT_ZERO;
        end else if (wait_cnt_r != CNT_MAX) begin
            wait_cnt_r <= wait_cnt_r + CNT_ONE;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FETCH: begin
                if (bus.mem_ready) begin
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next_s = MEMADR;
                    OP_RTYPE:          state_next_s = EXEC_R;
                    OP_IALU:           state_next_s = EXEC_I;
                    OP_BRANCH:         state_next_s = BRANCH;
                    OP_JAL:            state_next_s = JAL;
                    OP_AUIPC:          state_next_s = ALUWB;
                    default:           state_next_s = FETCH;
                endcase
            end
            MEMADR: begin
                if (bus.op[5]) begin
                    state_next_s = MEMWRITE;
                end else begin
                    state_next_s = MEMREAD;
                end
            end
            MEMREAD: begin
                if (bus.mem_ready) begin
                    state_next_s = MEMWB;
                end else if (timeout_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEMREAD;
                end
            end
            MEMWB: state_next_s = FETCH;
            MEMWRITE: begin
                if (bus.mem_ready || timeout_s) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEMWRITE;
                end
            end
            EXEC_R:  state_next_s = ALUWB;
            EXEC_I:  state_next_s = ALUWB;
            ALUWB:   state_next_s = FETCH;
            BRANCH:  state_next_s = FETCH;
            JAL:     state_next_s = ALUWB;
            default: state_next_s = FETCH;
        endcase
    end

    // Moore output decode, plus handshake gating and branch resolution
    always_comb begin
        mem_req_s    = 1'b0;
        pc_write_s   = 1'b0;
        adr_src_s    = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        illegal_op_s = 1'b0;
        result_src_s = RES_ALUOUT;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        alu_op_s     = ALUOP_ADD;
        case (state_r)
            FETCH: begin
                mem_req_s    = 1'b1;
                alu_src_b_s  = SRCB_FOUR;
                result_src_s = RES_ALURESULT;
                ir_write_s   = bus.mem_ready;
                pc_write_s   = bus.mem_ready;
            end
            DECODE: begin
                alu_src_a_s  = SRCA_OLDPC;
                alu_src_b_s  = SRCB_IMM;
                illegal_op_s = !op_supported(bus.op);
            end
            MEMADR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_s = 1'b1;
                adr_src_s = 1'b1;
            end
            MEMWB: begin
                result_src_s = RES_DATA;
                reg_write_s  = 1'b1;
            end
            MEMWRITE: begin
                mem_req_s   = 1'b1;
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            EXEC_R: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_op_s    = ALUOP_FUNCT;
            end
            EXEC_I: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write_s = 1'b1;
            end
            BRANCH: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_op_s    = ALUOP_SUB;
                pc_write_s  = branch_taken_s;
            end
            JAL: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_FOUR;
                pc_write_s  = 1'b1;
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op      (alu_op_s),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (alu_control_s)
    );

    // Enables are forced low while reset is held so an abandoned access
    // cannot leak a strobe; a timeout cycle suppresses all writes.
    assign bus.mem_req    = reset_n & mem_req_s;
    assign bus.PCWrite    = reset_n & pc_write_s & ~timeout_s;
    assign bus.IRWrite    = reset_n & ir_write_s & ~timeout_s;
    assign bus.MemWrite   = reset_n & mem_write_s & ~timeout_s;
    assign bus.RegWrite   = reset_n & reg_write_s;
    assign bus.illegal_op = reset_n & illegal_op_s;
    assign bus.bus_err    = reset_n & timeout_s;

    assign bus.AdrSrc     = adr_src_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ALUControl = alu_control_s;
    assign bus.ImmSrc     = imm_src_dec(bus.op);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl
//   Directed self-checking bench for multicycle_ctrl (TIMEOUT_CYCLES = 4).
//   Each check compares the full packed control word
//   {mem_req,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
//    ALUControl,ImmSrc,RegWrite,illegal_op,bus_err} against a hand value.
module tb_multicycle_ctrl;

    localparam logic B0 = 1'b0;
    localparam logic B1 = 1'b1;

    localparam logic [6:0] T_LOAD   = 7'b0000011;
    localparam logic [6:0] T_STORE  = 7'b0100011;
    localparam logic [6:0] T_RTYPE  = 7'b0110011;
    localparam logic [6:0] T_IALU   = 7'b0010011;
    localparam logic [6:0] T_BRANCH = 7'b1100011;
    localparam logic [6:0] T_JAL    = 7'b1101111;
    localparam logic [6:0] T_AUIPC  = 7'b0010111;
    localparam logic [6:0] T_BAD    = 7'b1111111;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [15:0] rtab [0:8];
    logic [4:0]  btab [0:4];

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .TIMEOUT_CYCLES (4),
        .CNT_W          (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Single comparison point for the whole bench
    task automatic chk_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] w(input logic mreq, input logic pcw, input logic adr,
                                      input logic mw, input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] ac, input logic [2:0] imm,
                                      input logic rw, input logic ill, input logic be);
        return {mreq, pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill, be};
    endfunction

    function automatic logic [19:0] obs();
        return {bus.mem_req, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
                bus.RegWrite, bus.illegal_op, bus.bus_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string tag, input logic [19:0] exp);
        #1;
        chk_eq(tag, obs(), exp);
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic z, input logic rdy);
        bus.op        = op;
        bus.funct3    = f3;
        bus.funct7b5  = f7;
        bus.zero      = z;
        bus.mem_ready = rdy;
    endtask

    // FETCH with immediate mem_ready, then DECODE
    task automatic fetch_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic z, input logic [2:0] imm, input logic ill);
        set_in(op, f3, f7, z, B1);
        expect_now("fetch", w(B1,B1,B0,B0,B1,2'b10,2'b00,2'b10,3'b000,imm,B0,B0,B0));
        step();
        expect_now("decode", w(B0,B0,B0,B0,B0,2'b00,2'b01,2'b01,3'b000,imm,B0,ill,B0));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] rv;
        logic [4:0]  bv;

        // {op, funct3, funct7b5, ALUSrcB, ALUControl}
        rtab[0] = {T_RTYPE, 3'b000, 1'b0, 2'b00, 3'b000};   // add
        rtab[1] = {T_RTYPE, 3'b000, 1'b1, 2'b00, 3'b001};   // sub
        rtab[2] = {T_RTYPE, 3'b100, 1'b0, 2'b00, 3'b100};   // xor
        rtab[3] = {T_RTYPE, 3'b110, 1'b0, 2'b00, 3'b011};   // or
        rtab[4] = {T_RTYPE, 3'b111, 1'b0, 2'b00, 3'b010};   // and
        rtab[5] = {T_RTYPE, 3'b010, 1'b0, 2'b00, 3'b101};   // slt
        rtab[6] = {T_RTYPE, 3'b001, 1'b0, 2'b00, 3'b000};   // sll -> add
        rtab[7] = {T_IALU,  3'b000, 1'b1, 2'b01, 3'b000};   // addi, instr[30]=1 -> add
        rtab[8] = {T_IALU,  3'b100, 1'b0, 2'b01, 3'b100};   // xori
        // {funct3, zero, PCWrite}
        btab[0] = {3'b000, 1'b1, 1'b1};   // beq taken
        btab[1] = {3'b001, 1'b1, 1'b0};   // bne not taken
        btab[2] = {3'b000, 1'b0, 1'b0};   // beq not taken
        btab[3] = {3'b001, 1'b0, 1'b1};   // bne taken
        btab[4] = {3'b100, 1'b1, 1'b0};   // blt: unsupported, not taken

        // Reset held with mem_ready high
        set_in(T_RTYPE, 3'b000, B0, B0, B1);
        step();
        step();
        expect_now("reset", w(B0,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B0));
        reset_n = 1'b1;
        expect_now("release_fetch", w(B1,B1,B0,B0,B1,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B0));
        step();
        expect_now("add_decode", w(B0,B0,B0,B0,B0,2'b00,2'b01,2'b01,3'b000,3'b000,B0,B0,B0));
        step();
        expect_now("add_exec", w(B0,B0,B0,B0,B0,2'b00,2'b10,2'b00,3'b000,3'b000,B0,B0,B0));
        step();
        expect_now("add_wb", w(B0,B0,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b000,B1,B0,B0));
        step();

        // R-type and I-ALU decode table
        for (int i = 0; i < 9; i++) begin
            rv = rtab[i];
            fetch_decode(rv[15:9], rv[8:6], rv[5], B0, 3'b000, B0);
            expect_now($sformatf("exec_%0d", i),
                       w(B0,B0,B0,B0,B0,2'b00,2'b10,rv[4:3],rv[2:0],3'b000,B0,B0,B0));
            step();
            expect_now($sformatf("aluwb_%0d", i),
                       w(B0,B0,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b000,B1,B0,B0));
            step();
        end

        // lw with three wait cycles in MEMREAD
        fetch_decode(T_LOAD, 3'b010, B0, B0, 3'b000, B0);
        expect_now("lw_memadr", w(B0,B0,B0,B0,B0,2'b00,2'b10,2'b01,3'b000,3'b000,B0,B0,B0));
        step();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_now("lw_wait", w(B1,B0,B1,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b000,B0,B0,B0));
            step();
        end
        bus.mem_ready = 1'b1;
        expect_now("lw_done", w(B1,B0,B1,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b000,B0,B0,B0));
        step();
        expect_now("lw_memwb", w(B0,B0,B0,B0,B0,2'b01,2'b00,2'b00,3'b000,3'b000,B1,B0,B0));
        step();

        // sw
        fetch_decode(T_STORE, 3'b010, B0, B0, 3'b001, B0);
        expect_now("sw_memadr", w(B0,B0,B0,B0,B0,2'b00,2'b10,2'b01,3'b000,3'b001,B0,B0,B0));
        step();
        expect_now("sw_memwrite", w(B1,B0,B1,B1,B0,2'b00,2'b00,2'b00,3'b000,3'b001,B0,B0,B0));
        step();

        // Branch resolution table
        for (int i = 0; i < 5; i++) begin
            bv = btab[i];
            fetch_decode(T_BRANCH, bv[4:2], B0, bv[1], 3'b010, B0);
            expect_now($sformatf("branch_%0d", i),
                       w(B0,bv[0],B0,B0,B0,2'b00,2'b10,2'b00,3'b001,3'b010,B0,B0,B0));
            step();
        end

        // jal and auipc
        fetch_decode(T_JAL, 3'b000, B0, B0, 3'b011, B0);
        expect_now("jal", w(B0,B1,B0,B0,B0,2'b00,2'b01,2'b10,3'b000,3'b011,B0,B0,B0));
        step();
        expect_now("jal_wb", w(B0,B0,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b011,B1,B0,B0));
        step();
        fetch_decode(T_AUIPC, 3'b000, B0, B0, 3'b100, B0);
        expect_now("auipc_wb", w(B0,B0,B0,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b100,B1,B0,B0));
        step();

        // Illegal opcode: pulse in DECODE, back to FETCH
        fetch_decode(T_BAD, 3'b000, B0, B0, 3'b000, B1);

        // FETCH timeout: four wait cycles then bus_err
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_now("fetch_wait", w(B1,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B0));
            step();
        end
        expect_now("fetch_timeout", w(B1,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B1));
        step();
        expect_now("fetch_reenter", w(B1,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B0));
        for (int i = 0; i < 4; i++) begin
            step();
        end
        // mem_ready in the limit cycle wins
        bus.mem_ready = 1'b1;
        expect_now("fetch_late_ready", w(B1,B1,B0,B0,B1,2'b10,2'b00,2'b10,3'b000,3'b000,B0,B0,B0));
        step();
        expect_now("late_decode", w(B0,B0,B0,B0,B0,2'b00,2'b01,2'b01,3'b000,3'b000,B0,B1,B0));
        step();

        // MEMWRITE timeout suppresses the write strobe
        fetch_decode(T_STORE, 3'b010, B0, B0, 3'b001, B0);
        step();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_now("sw_wait", w(B1,B0,B1,B1,B0,2'b00,2'b00,2'b00,3'b000,3'b001,B0,B0,B0));
            step();
        end
        expect_now("sw_timeout", w(B1,B0,B1,B0,B0,2'b00,2'b00,2'b00,3'b000,3'b001,B0,B0,B1));
        step();
        expect_now("sw_to_fetch", w(B1,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b001,B0,B0,B0));

        // Reset in the middle of MEMWRITE
        fetch_decode(T_STORE, 3'b010, B0, B0, 3'b001, B0);
        step();
        bus.mem_ready = 1'b0;
        expect_now("rst_pre_memwrite", w(B1,B0,B1,B1,B0,2'b00,2'b00,2'b00,3'b000,3'b001,B0,B0,B0));
        reset_n = 1'b0;
        expect_now("rst_mid_access", w(B0,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b001,B0,B0,B0));
        step();
        bus.mem_ready = 1'b1;
        expect_now("rst_held", w(B0,B0,B0,B0,B0,2'b10,2'b00,2'b10,3'b000,3'b001,B0,B0,B0));
        reset_n = 1'b1;
        expect_now("rst_release", w(B1,B1,B0,B0,B1,2'b10,2'b00,2'b10,3'b000,3'b001,B0,B0,B0));
        step();
        expect_now("rst_decode", w(B0,B0,B0,B0,B0,2'b00,2'b01,2'b01,3'b000,3'b001,B0,B0,B0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared single-port memory, IR, PC and the single ALU across fetch, decode, execute, memory and writeback states.
- Generates every datapath select and write-enable, including ImmSrc for the immediate extender.
- Sits between the instruction register fields and the datapath muxes; handshakes with memory through mem_req/mem_ready.

Parameters:
- TIMEOUT_CYCLES, 0: max wait cycles per memory access; 0 disables the timeout.
- CNT_W, 8: width of the wait counter; must satisfy TIMEOUT_CYCLES < 2**CNT_W.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- op  in  7  instr[6:0].
- funct3  in  3  instr[14:12].
- funct7b5  in  1  instr[30].
- zero  in  1  ALU zero flag, valid in the BRANCH state.
- mem_ready  in  1  memory access completes this cycle.
- mem_req  out  1  memory access request.
- PCWrite  out  1  PC register enable.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR/OldPC enable.
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- RegWrite  out  1  register file write enable.
- illegal_op  out  1  1-cycle pulse on an unsupported opcode.
- bus_err  out  1  1-cycle pulse on a memory timeout.

Behaviour:
- Outputs are a Moore decode of state; the only exceptions are handshake gating, branch resolution and ImmSrc.
- ImmSrc is a combinational decode of op in every state. Mapping: lw, I-ALU → 000; sw → 001; branch → 010; jal → 011; auipc → 100; all other opcodes → 000 (never X).
- ALUOp (internal): 00 add, 01 sub, 10 funct-decoded.
- ALUOp 10, funct3 decode:
  - 000: sub if op[5] & funct7b5, else add.
  - 010: slt.
  - 100: xor.
  - 110: or.
  - 111: and.
  - any other funct3: add.
- Reset:
  - State forced to FETCH.
  - wait_cnt forced to 0.
  - While reset_n = 0: PCWrite, IRWrite, RegWrite, MemWrite, mem_req, illegal_op and bus_err are 0.
  - Release takes effect at the first clk edge after deassertion.
  - Reset mid-access abandons the access; no write strobe leaks.
- FETCH:
  - Drives mem_req = 1, AdrSrc = 0, ALUSrcA = 00, ALUSrcB = 10, ALUOp = 00, ResultSrc = 10.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Drives ALUSrcA = 01, ALUSrcB = 01, ALUOp = 00, so ALUOut = OldPC + imm.
  - Next state by op:
    - lw/sw → MEMADR.
    - R-type → EXEC_R.
    - I-ALU → EXEC_I.
    - beq/bne → BRANCH.
    - jal → JAL.
    - auipc → ALUWB.
    - any other op → FETCH, with illegal_op = 1 this cycle.
- MEMADR: drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = 00; goes to MEMREAD if op[5] = 0, else MEMWRITE.
- MEMREAD: drives mem_req = 1, AdrSrc = 1; on mem_ready goes to MEMWB.
- MEMWB: drives ResultSrc = 01, RegWrite = 1; goes to FETCH.
- MEMWRITE: drives mem_req = 1, AdrSrc = 1, MemWrite = 1; on mem_ready goes to FETCH.
- EXEC_R: drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = 10; goes to ALUWB.
- EXEC_I: drives ALUSrcA = 10, ALUSrcB = 01, ALUOp = 10; goes to ALUWB.
- ALUWB: drives ResultSrc = 00, RegWrite = 1; goes to FETCH.
- BRANCH:
  - Drives ALUSrcA = 10, ALUSrcB = 00, ALUOp = 01, ResultSrc = 00.
  - PCWrite = zero XOR funct3[0] (beq/bne).
  - Other funct3 values are treated as not-taken.
  - Goes to FETCH.
- JAL: drives ALUSrcA = 01, ALUSrcB = 10, ALUOp = 00, ResultSrc = 00, PCWrite = 1; goes to ALUWB (rd = OldPC + 4).
- Memory wait and timeout:
  - wait_cnt increments each cycle mem_req = 1 and mem_ready = 0; it clears on completion or state exit.
  - If TIMEOUT_CYCLES > 0 and wait_cnt reaches TIMEOUT_CYCLES with no mem_ready:
    - bus_err pulses.
    - State goes to FETCH.
    - No write enables assert that cycle.
  - mem_ready arriving in the timeout cycle wins: normal completion, no bus_err.
- mem_ready outside a request is ignored.
- Selects not listed for a state are driven 0.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state_t enum (FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL).
  - Opcode constants.
  - ALUControl, ImmSrc, ResultSrc and ALUSrc encodings.
- One natural sub-module: alu_ctrl_dec (ALUOp, funct3, funct7b5, op5 → ALUControl), purely combinational.

Test Plan:
- Reset held low with mem_ready = 1 → all enables 0. After release: FETCH, mem_req = 1, IRWrite = 1, PCWrite = 1 on the first edge.
- add (0x00B50533), mem_ready = 1 → FETCH, DECODE, EXEC_R (ALUControl = 000), ALUWB (RegWrite = 1); 4 cycles. sub (funct7b5 = 1) → ALUControl = 001.
- lw with mem_ready low for 3 cycles in MEMREAD → mem_req held, AdrSrc = 1, then MEMWB with ResultSrc = 01. sw → MemWrite = 1 only in MEMWRITE, ImmSrc = 001.
- beq with zero = 1 → PCWrite = 1 in BRANCH. bne with zero = 1 → PCWrite = 0. ImmSrc = 010.
- TIMEOUT_CYCLES = 4, no mem_ready in FETCH → bus_err pulses once, FETCH re-entered; mem_ready in the 4th wait cycle → no bus_err.
- op = 0x7F → illegal_op pulse in DECODE, then FETCH; reset_n asserted during MEMWRITE → MemWrite drops immediately, state FETCH.
